// File: rtl/vector_builder_pkg.sv
// Shared types and constants for the vector builder: FSM state encoding,
// location width and the saturation limit of the beat counter.
package vector_builder_pkg;

  localparam int LOC_W = 16;
  localparam logic [LOC_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/loc_decode.sv
// Combinational decoder: turns a bit location into a WIDTH-bit one-hot mask
// and reports whether the location addresses a bit of the vector at all.
module loc_decode
  import vector_builder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [LOC_W-1:0] location,
  output logic [WIDTH-1:0] onehot,
  output logic             in_range
);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_range = (32'(location) < WIDTH);
    onehot   = '0;
    if (in_range) onehot = WIDTH'(1) << location;
  end

endmodule

// File: rtl/vector_builder.sv
// Accumulates bit locations into a WIDTH-bit vector over a frame, then holds
// the result with error flags until the consumer takes it.
module vector_builder
  import vector_builder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [LOC_W-1:0]  location,
  input  logic              in_last,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WIDTH-1:0]  vector,
  output logic [LOC_W-1:0]  count,
  output logic              dup_err,
  output logic              range_err
);

  state_e state, state_next;

  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic             accept;
  logic             release_frame;
  logic             dup_hit;

  loc_decode #(.WIDTH(WIDTH)) u_loc_decode (
    .location (location),
    .onehot   (onehot),
    .in_range (in_range)
  );

  // Handshake outputs come straight from the state register.
  assign in_rdy        = (state == ACCUM);
  assign out_vld       = (state == HOLD);
  assign accept        = in_vld  && in_rdy;
  assign release_frame = out_vld && out_rdy;
  assign dup_hit       = in_range && |(vector & onehot);

  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (accept && in_last) state_next = HOLD;
      HOLD:  if (out_rdy)           state_next = ACCUM;
      default:                      state_next = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector    <= '0;
      count     <= '0;
      dup_err   <= 1'b0;
      range_err <= 1'b0;
    end else if (release_frame) begin
      vector    <= '0;
      count     <= '0;
      dup_err   <= 1'b0;
      range_err <= 1'b0;
    end else if (accept) begin
      vector <= vector | onehot;
      if (count != COUNT_MAX) count <= count + 1'b1;
      if (dup_hit)   dup_err   <= 1'b1;
      if (!in_range) range_err <= 1'b1;
    end
  end

endmodule
